// File: rtl/rf_pkg.sv
// Shared constants and types for the 16 x 16-bit datapath register file.
package rf_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 4;
   localparam int DEPTH      = 2 ** ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0] rf_data_t;
   typedef logic [ADDR_WIDTH-1:0] rf_addr_t;

   localparam rf_data_t RF_RESET_VALUE = 16'h0000;

endpackage

// File: rtl/rf_write_decoder.sv
// Turns the two (enable, address) write requests into one strobe per register
// plus a per-register select that picks port 2 data whenever port 2 targets it,
// so port 2 wins a same-address collision.
module rf_write_decoder
   import rf_pkg::*;
(
   input  logic [1:0]       we,
   input  rf_addr_t         addr1,
   input  rf_addr_t         addr2,
   output logic [DEPTH-1:0] strobe,
   output logic [DEPTH-1:0] sel_port2
);

   // Enables gate the address compares, so unknown addresses with both
   // enables low still produce all-zero strobes.
   always_comb begin
      strobe    = '0;
      sel_port2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sel_port2[i] = we[1] && (addr2 == rf_addr_t'(i));
         strobe[i]    = (we[0] && (addr1 == rf_addr_t'(i))) || sel_port2[i];
      end
   end

endmodule

// File: rtl/register_file.sv
// 16 x 16-bit register file: two write ports (port 2 has priority on a
// same-address write), two combinational read ports gated by READ_ENABLE.
// No write-to-read bypass: reads see a write only after the clock edge.
module register_file
   import rf_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  READ_ENABLE,
   input  logic [1:0]            WRITE_ENABLE,
   input  logic [ADDR_WIDTH-1:0] OP1_ADDRESS,
   input  logic [ADDR_WIDTH-1:0] OP2_ADDRESS,
   input  logic [ADDR_WIDTH-1:0] WRITE_ADDRESS1,
   input  logic [ADDR_WIDTH-1:0] WRITE_ADDRESS2,
   input  logic [DATA_WIDTH-1:0] WRITE_DATA1,
   input  logic [DATA_WIDTH-1:0] WRITE_DATA2,
   output logic [DATA_WIDTH-1:0] OP1_OUT,
   output logic [DATA_WIDTH-1:0] OP2_OUT
);

   rf_data_t         regs [DEPTH];
   logic [DEPTH-1:0] wr_strobe;
   logic [DEPTH-1:0] wr_sel_port2;

   rf_write_decoder u_write_decoder (
      .we        (WRITE_ENABLE),
      .addr1     (WRITE_ADDRESS1),
      .addr2     (WRITE_ADDRESS2),
      .strobe    (wr_strobe),
      .sel_port2 (wr_sel_port2)
   );

   // Register array: cleared asynchronously, each entry loads its selected port's data when strobed.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= RF_RESET_VALUE;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_strobe[i]) begin
               regs[i] <= wr_sel_port2[i] ? WRITE_DATA2 : WRITE_DATA1;
            end
         end
      end
   end

   // Read muxes: zero-latency operand fetch, forced to zero when reads are disabled.
   always_comb begin
      OP1_OUT = '0;
      OP2_OUT = '0;
      if (READ_ENABLE) begin
         OP1_OUT = regs[OP1_ADDRESS];
         OP2_OUT = regs[OP2_ADDRESS];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by a
// random write/read phase, all compared against a plain array model.
module tb_register_file;

   logic        CLK;
   logic        RST;
   logic        READ_ENABLE;
   logic [1:0]  WRITE_ENABLE;
   logic [3:0]  OP1_ADDRESS;
   logic [3:0]  OP2_ADDRESS;
   logic [3:0]  WRITE_ADDRESS1;
   logic [3:0]  WRITE_ADDRESS2;
   logic [15:0] WRITE_DATA1;
   logic [15:0] WRITE_DATA2;
   logic [15:0] OP1_OUT;
   logic [15:0] OP2_OUT;

   logic [15:0] model [16];
   int          checks = 0;
   int          errors = 0;

   register_file dut (
      .CLK            (CLK),
      .RST            (RST),
      .READ_ENABLE    (READ_ENABLE),
      .WRITE_ENABLE   (WRITE_ENABLE),
      .OP1_ADDRESS    (OP1_ADDRESS),
      .OP2_ADDRESS    (OP2_ADDRESS),
      .WRITE_ADDRESS1 (WRITE_ADDRESS1),
      .WRITE_ADDRESS2 (WRITE_ADDRESS2),
      .WRITE_DATA1    (WRITE_DATA1),
      .WRITE_DATA2    (WRITE_DATA2),
      .OP1_OUT        (OP1_OUT),
      .OP2_OUT        (OP2_OUT)
   );

   initial CLK = 1'b0;
   always #20 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] expect_rd(input logic [3:0] a);
      return READ_ENABLE ? model[a] : 16'h0000;
   endfunction

   // Read every register through both ports (port 2 sweeps in reverse), 1 ns per step.
   task automatic sweep(input string tag);
      for (int i = 0; i < 16; i++) begin
         OP1_ADDRESS = 4'(i);
         OP2_ADDRESS = 4'(15 - i);
         #1;
         chk({tag, "_op1"}, OP1_OUT, expect_rd(4'(i)));
         chk({tag, "_op2"}, OP2_OUT, expect_rd(4'(15 - i)));
      end
   endtask

   // One write cycle: inputs applied at the falling edge, old data checked
   // before the rising edge, new data checked just after it.
   task automatic do_write(input string tag, input logic [1:0] we,
                           input logic [3:0] a1, input logic [15:0] d1,
                           input logic [3:0] a2, input logic [15:0] d2);
      @(negedge CLK);
      WRITE_ENABLE   = we;
      WRITE_ADDRESS1 = a1;
      WRITE_DATA1    = d1;
      WRITE_ADDRESS2 = a2;
      WRITE_DATA2    = d2;
      OP1_ADDRESS    = a1;
      OP2_ADDRESS    = a2;
      #1;
      chk({tag, "_pre_op1"}, OP1_OUT, expect_rd(a1));
      chk({tag, "_pre_op2"}, OP2_OUT, expect_rd(a2));
      @(posedge CLK);
      #1;
      if (!RST) begin
         if (we[0]) model[a1] = d1;
         if (we[1]) model[a2] = d2;
      end
      chk({tag, "_post_op1"}, OP1_OUT, expect_rd(a1));
      chk({tag, "_post_op2"}, OP2_OUT, expect_rd(a2));
      WRITE_ENABLE = 2'b00;
   endtask

   initial begin
      logic [1:0]  we;
      logic [3:0]  a1, a2;
      logic [15:0] d1, d2;

      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      RST            = 1'b1;
      READ_ENABLE    = 1'b1;
      WRITE_ENABLE   = 2'b00;
      OP1_ADDRESS    = 4'h0;
      OP2_ADDRESS    = 4'h0;
      WRITE_ADDRESS1 = 4'h0;
      WRITE_ADDRESS2 = 4'h0;
      WRITE_DATA1    = 16'h0000;
      WRITE_DATA2    = 16'h0000;
      #3;
      sweep("in_reset");
      @(negedge CLK);
      RST = 1'b0;

      // 1. post-reset contents all zero
      sweep("reset_clear");

      // 2. single write on port 1
      do_write("wr_p1", 2'b01, 4'hA, 16'hFFFF, 4'h3, 16'h5555);
      sweep("after_p1");

      // 3. dual write to distinct registers
      do_write("wr_dual", 2'b11, 4'hB, 16'hFFFF, 4'h0, 16'hABCD);
      sweep("after_dual");

      // 4. collision: port 2 wins
      do_write("wr_coll", 2'b11, 4'h5, 16'h1111, 4'h5, 16'h2222);
      chk("coll_model_r5", model[5], 16'h2222);
      sweep("after_coll");

      // port 2 alone
      do_write("wr_p2", 2'b10, 4'h7, 16'h9999, 4'hC, 16'h0F0F);
      sweep("after_p2");

      // no enables with unknown address/data must not disturb anything
      @(negedge CLK);
      WRITE_ENABLE   = 2'b00;
      WRITE_ADDRESS1 = 4'hx;
      WRITE_ADDRESS2 = 4'hx;
      WRITE_DATA1    = 16'hxxxx;
      WRITE_DATA2    = 16'hxxxx;
      @(posedge CLK);
      #1;
      sweep("we00_x");

      // 5. read enable gating
      do_write("wr_r3", 2'b01, 4'h3, 16'h1234, 4'h3, 16'h0000);
      @(negedge CLK);
      READ_ENABLE = 1'b0;
      OP1_ADDRESS = 4'h3;
      OP2_ADDRESS = 4'h3;
      #1;
      chk("re0_op1", OP1_OUT, 16'h0000);
      chk("re0_op2", OP2_OUT, 16'h0000);
      sweep("re0_sweep");
      READ_ENABLE = 1'b1;
      OP1_ADDRESS = 4'h3;
      OP2_ADDRESS = 4'h3;
      #1;
      chk("re1_op1", OP1_OUT, 16'h1234);
      chk("re1_op2", OP2_OUT, 16'h1234);

      // random phase
      for (int n = 0; n < 200; n++) begin
         we = 2'($urandom_range(0, 3));
         a1 = 4'($urandom_range(0, 15));
         a2 = (($urandom_range(0, 7)) == 0) ? a1 : 4'($urandom_range(0, 15));
         d1 = 16'($urandom);
         d2 = 16'($urandom);
         READ_ENABLE = ($urandom_range(0, 9) != 0);
         do_write("rand", we, a1, d1, a2, d2);
      end
      READ_ENABLE = 1'b1;
      sweep("after_rand");

      // 6. asynchronous reset mid-cycle, no clock edge needed
      @(posedge CLK);
      #2;
      RST = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      #1;
      sweep("async_rst");
      do_write("wr_in_rst", 2'b11, 4'h6, 16'hDEAD, 4'h9, 16'hBEEF);
      OP1_ADDRESS = 4'h6;
      OP2_ADDRESS = 4'h9;
      #1;
      chk("rst_hold_r6", OP1_OUT, 16'h0000);
      chk("rst_hold_r9", OP2_OUT, 16'h0000);
      @(negedge CLK);
      RST = 1'b0;
      do_write("wr_after_rst", 2'b01, 4'h6, 16'hCAFE, 4'h0, 16'h0000);
      sweep("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
